// File: rtl/wave_capture_pkg.sv
// -----------------------------------------------------------------------------
// wave_capture_pkg
//   Shared definitions for the waveform capture block.
//   - state_t              : capture FSM encoding (ARMED / ACTIVE / WAIT)
//   - wave_capture_debug_t : debug bundle exposing FSM state and prev_sample
//   - to_offset_binary()   : converts the upper byte of a two's-complement
//                            sample to offset binary for the display RAM
// -----------------------------------------------------------------------------
package wave_capture_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    typedef struct packed {
        state_t      state;
        logic [15:0] prev_sample;
    } wave_capture_debug_t;

    // Takes sample[15:8]; flipping the sign bit maps -128..127 onto 0..255.
    function automatic logic [7:0] to_offset_binary(input logic [7:0] sample_hi);
        return sample_hi ^ 8'h80;
    endfunction

endpackage

// File: rtl/wave_capture_crossing_detector.sv
// -----------------------------------------------------------------------------
// crossing_detector
//   Holds the previous accepted sample and flags a rising zero crossing
//   (previous sample negative, current sample non-negative).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   new_sample_ready  : one-cycle strobe, new_sample_in valid
//   new_sample_in     : signed 16-bit sample
//   prev_sample       : last sample accepted (0 after reset)
//   rising            : combinational, high only in a strobe cycle that
//                       completes a negative -> non-negative transition
// -----------------------------------------------------------------------------
module crossing_detector (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    output logic [15:0] prev_sample,
    output logic        rising
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sample <= 16'h0000;
        end else if (new_sample_ready) begin
            prev_sample <= new_sample_in;
        end
    end

    // prev_sample resets to 0 (non-negative), so nothing triggers until a
    // negative sample has been seen.
    assign rising = new_sample_ready & prev_sample[15] & ~new_sample_in[15];

endmodule

// File: rtl/wave_capture.sv
// -----------------------------------------------------------------------------
// wave_capture
//   Captures one screen-width (2^ADDR_WIDTH samples) of the audio stream into
//   a ping-pong RAM, starting on a rising zero crossing. read_index names the
//   half the display reads; captures go only to the other half.
//
// Optional feature (macro WAVE_CAPTURE_TIMEOUT_EN):
//   While ARMED, strobes are counted; once TIMEOUT strobes have passed without
//   a crossing, the next strobe triggers anyway so silence/DC still refresh
//   the display. Without the macro ARMED waits for a crossing indefinitely.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   new_sample_ready    : one-cycle strobe, new_sample_in valid
//   new_sample_in       : signed 16-bit sample
//   wave_display_idle   : display not reading RAM, buffer swap allowed
//   write_address       : {~read_index, sample_count}, registered
//   write_enable        : one-cycle RAM write strobe, registered
//   write_sample        : offset-binary upper byte of the sample, registered
//   read_index          : half the display reads, toggles on each swap
//   debug               : FSM state and prev_sample
//
// Handshake: there is no back-pressure. Every cycle with new_sample_ready
// high is an accepted sample; a sample that is written appears on the write
// port exactly one cycle later with write_enable high for that one cycle.
// -----------------------------------------------------------------------------
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
`ifdef WAVE_CAPTURE_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 2048
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [15:0]           new_sample_in,
    input  logic                  wave_display_idle,
    output logic [ADDR_WIDTH:0]   write_address,
    output logic                  write_enable,
    output logic [7:0]            write_sample,
    output logic                  read_index,
    output wave_capture_debug_t   debug
);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] sample_count, sample_count_n;
    logic                  read_index_n;
    logic                  write_enable_n;
    logic [ADDR_WIDTH:0]   write_address_n;
    logic [7:0]            write_sample_n;

    logic [15:0]           prev_sample;
    logic                  rising;
    logic                  timeout_hit;
    logic                  trigger;

    crossing_detector u_crossing_detector (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .prev_sample      (prev_sample),
        .rising           (rising)
    );

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] timeout_count;

    // Held at zero outside ARMED, so it starts from zero on every entry.
    // Saturates at TIMEOUT; the strobe seen at saturation is the forced trigger.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_count <= '0;
        end else if (state != ARMED) begin
            timeout_count <= '0;
        end else if (new_sample_ready && !timeout_hit) begin
            timeout_count <= timeout_count + 1'b1;
        end
    end

    assign timeout_hit = (timeout_count == TW'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    assign trigger = rising | (new_sample_ready & timeout_hit);

    // Next-state and next-output logic. The write port holds its last
    // address/sample between writes; only write_enable pulses.
    always_comb begin
        state_n         = state;
        sample_count_n  = sample_count;
        read_index_n    = read_index;
        write_enable_n  = 1'b0;
        write_address_n = write_address;
        write_sample_n  = write_sample;

        case (state)
            ARMED: begin
                if (trigger) begin
                    write_enable_n  = 1'b1;
                    write_address_n = {~read_index, {ADDR_WIDTH{1'b0}}};
                    write_sample_n  = to_offset_binary(new_sample_in[15:8]);
                    sample_count_n  = ADDR_WIDTH'(1);
                    state_n         = ACTIVE;
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    write_enable_n  = 1'b1;
                    write_address_n = {~read_index, sample_count};
                    write_sample_n  = to_offset_binary(new_sample_in[15:8]);
                    // The last write of a capture wraps the count back to 0.
                    sample_count_n  = sample_count + 1'b1;
                    if (sample_count == {ADDR_WIDTH{1'b1}}) begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                // A strobe arriving with idle only updates prev_sample
                // (inside the detector); it can never start a capture here.
                if (wave_display_idle) begin
                    read_index_n = ~read_index;
                    state_n      = ARMED;
                end
            end
            default: begin
                state_n = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ARMED;
            sample_count  <= '0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= 8'h00;
        end else begin
            state         <= state_n;
            sample_count  <= sample_count_n;
            read_index    <= read_index_n;
            write_enable  <= write_enable_n;
            write_address <= write_address_n;
            write_sample  <= write_sample_n;
        end
    end

    assign debug.state       = state;
    assign debug.prev_sample = prev_sample;

endmodule
